// File: rtl/galaga_pkg.sv
// rtl/galaga_pkg.sv - shared state encoding, default start key and grid index helper
package galaga_pkg;

  typedef enum logic [2:0] {
    S_START,
    S_PLAY,
    S_CLEAR,
    S_DYING,
    S_GAMEOVER
  } game_state_t;

  localparam logic [7:0] START_KEY_ENTER = 8'h28;

  // Flat alive-mask bit position of enemy (row, col) in a grid that is cols wide.
  function automatic int idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector; rise_o lags the input rise by one clock
module rise_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;
  logic rise_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      d_q    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      d_q    <= d_i;
      rise_q <= d_i & ~d_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - Galaga game-flow FSM with enemy alive mask, score, lives and level
module game_flow_controller
  import galaga_pkg::*;
#(
  parameter int         ROWS         = 3,
  parameter int         COLS         = 6,
  parameter int         SCORE_W      = 8,
  parameter int         POINTS       = 1,
  parameter int         LIVES_INIT   = 3,
  parameter int         LIVES_W      = 2,
  parameter int         LEVEL_W      = 3,
  parameter int         MAX_LEVEL    = 4,
  parameter logic [7:0] START_KEY    = START_KEY_ENTER,
  parameter int         CLEAR_FRAMES = 120,
  parameter int         DEATH_FRAMES = 90,
  parameter int         TIMER_W      = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      frame_clk_i,
  input  logic [7:0]                keycode_i,
  input  logic                      hit_valid_i,
  input  logic [$clog2(ROWS)-1:0]   hit_row_i,
  input  logic [$clog2(COLS)-1:0]   hit_col_i,
  input  logic                      player_hit_i,
  input  logic                      enemy_landed_i,
  output logic                      start_o,
  output logic                      play_o,
  output logic                      level_clear_o,
  output logic                      dying_o,
  output logic                      gameover_o,
  output logic                      won_o,
  output logic                      respawn_o,
  output logic [ROWS*COLS-1:0]      alive_mask_o,
  output logic [SCORE_W-1:0]        score_o,
  output logic [LIVES_W-1:0]        lives_o,
  output logic [LEVEL_W-1:0]        level_o
);

  localparam int MASK_W    = ROWS * COLS;
  localparam int SCORE_MAX = 2 ** SCORE_W - 1;

  game_state_t         state_q, state_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                won_q, won_d;
  logic                start_q, start_d, play_q, play_d, clear_q, clear_d;
  logic                dying_q, dying_d, over_q, over_d, respawn_q, respawn_d;

  logic                frame_tick, key_press;
  logic [MASK_W-1:0]   hit_onehot;
  logic                hit_in_range, kill;
  logic [SCORE_W-1:0]  score_sat;

  rise_detect u_frame_rise (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (frame_clk_i),
    .rise_o  (frame_tick)
  );

  rise_detect u_key_rise (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (keycode_i == START_KEY),
    .rise_o  (key_press)
  );

  assign hit_in_range = (int'(hit_row_i) < ROWS) && (int'(hit_col_i) < COLS);
  assign hit_onehot   = MASK_W'(1) << idx(int'(hit_row_i), int'(hit_col_i), COLS);
  assign kill         = hit_valid_i && hit_in_range && |(mask_q & hit_onehot);
  assign score_sat    = (int'(score_q) + POINTS >= SCORE_MAX) ? SCORE_W'(SCORE_MAX)
                                                              : score_q + SCORE_W'(POINTS);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_START;
      mask_q    <= '1;
      score_q   <= '0;
      lives_q   <= LIVES_W'(LIVES_INIT);
      level_q   <= LEVEL_W'(1);
      timer_q   <= '0;
      won_q     <= 1'b0;
      start_q   <= 1'b1;
      play_q    <= 1'b0;
      clear_q   <= 1'b0;
      dying_q   <= 1'b0;
      over_q    <= 1'b0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      timer_q   <= timer_d;
      won_q     <= won_d;
      start_q   <= start_d;
      play_q    <= play_d;
      clear_q   <= clear_d;
      dying_q   <= dying_d;
      over_q    <= over_d;
      respawn_q <= respawn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    score_d = score_q;
    lives_d = lives_q;
    level_d = level_q;
    won_d   = won_q;
    timer_d = timer_q;
    unique case (state_q)
      S_START: begin
        if (key_press) begin
          state_d = S_PLAY;
          mask_d  = '1;
          score_d = '0;
          lives_d = LIVES_W'(LIVES_INIT);
          level_d = LEVEL_W'(1);
        end
      end
      S_PLAY: begin
        if (kill) begin
          mask_d  = mask_q & ~hit_onehot;
          score_d = score_sat;
        end
        // A death wins over an emptied mask, but the kill above still lands.
        if (player_hit_i | enemy_landed_i) begin
          state_d = S_DYING;
          lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
        end else if (mask_d == '0) begin
          state_d = S_CLEAR;
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (timer_q == TIMER_W'(DEATH_FRAMES - 1)) begin
            if (lives_q == '0) begin
              state_d = S_GAMEOVER;
              won_d   = 1'b0;
            end else begin
              state_d = (mask_q == '0) ? S_CLEAR : S_PLAY;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (frame_tick) begin
          if (timer_q == TIMER_W'(CLEAR_FRAMES - 1)) begin
            if (level_q == LEVEL_W'(MAX_LEVEL)) begin
              state_d = S_GAMEOVER;
              won_d   = 1'b1;
            end else begin
              state_d = S_PLAY;
              mask_d  = '1;
              level_d = (level_q == '1) ? level_q : level_q + 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_GAMEOVER: begin
        if (key_press) begin
          state_d = S_START;
          won_d   = 1'b0;
        end
      end
      default: state_d = S_START;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_comb begin
    start_d   = (state_d == S_START);
    play_d    = (state_d == S_PLAY);
    clear_d   = (state_d == S_CLEAR);
    dying_d   = (state_d == S_DYING);
    over_d    = (state_d == S_GAMEOVER);
    respawn_d = (state_q == S_DYING) && (state_d != S_DYING) && (lives_q != '0);
  end

  assign start_o       = start_q;
  assign play_o        = play_q;
  assign level_clear_o = clear_q;
  assign dying_o       = dying_q;
  assign gameover_o    = over_q;
  assign won_o         = won_q;
  assign respawn_o     = respawn_q;
  assign alive_mask_o  = mask_q;
  assign score_o       = score_q;
  assign lives_o       = lives_q;
  assign level_o       = level_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - randomized self-checking bench against a behavioural game model
module tb_game_flow_controller;

  localparam int ROWS = 3;
  localparam int COLS = 6;
  localparam int M_START = 0, M_PLAY = 1, M_CLEAR = 2, M_DYING = 3, M_OVER = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, fclk = 1'b0, hv = 1'b0, ph = 1'b0, el = 1'b0;
  logic [7:0] key = 8'h00;
  logic [1:0] hr = '0;
  logic [2:0] hc = '0;

  logic        a_start, a_play, a_clear, a_dying, a_over, a_won, a_resp;
  logic [17:0] a_mask;
  logic [7:0]  a_score;
  logic [1:0]  a_lives;
  logic [2:0]  a_level;
  logic        b_start, b_play, b_clear, b_dying, b_over, b_won, b_resp;
  logic [17:0] b_mask;
  logic [3:0]  b_score;
  logic [1:0]  b_lives;
  logic [2:0]  b_level;

  game_flow_controller u_a (
    .clk_i(clk), .reset_i(rst), .frame_clk_i(fclk), .keycode_i(key),
    .hit_valid_i(hv), .hit_row_i(hr), .hit_col_i(hc), .player_hit_i(ph), .enemy_landed_i(el),
    .start_o(a_start), .play_o(a_play), .level_clear_o(a_clear), .dying_o(a_dying),
    .gameover_o(a_over), .won_o(a_won), .respawn_o(a_resp), .alive_mask_o(a_mask),
    .score_o(a_score), .lives_o(a_lives), .level_o(a_level)
  );

  game_flow_controller #(.SCORE_W(4), .POINTS(3)) u_b (
    .clk_i(clk), .reset_i(rst), .frame_clk_i(fclk), .keycode_i(key),
    .hit_valid_i(hv), .hit_row_i(hr), .hit_col_i(hc), .player_hit_i(ph), .enemy_landed_i(el),
    .start_o(b_start), .play_o(b_play), .level_clear_o(b_clear), .dying_o(b_dying),
    .gameover_o(b_over), .won_o(b_won), .respawn_o(b_resp), .alive_mask_o(b_mask),
    .score_o(b_score), .lives_o(b_lives), .level_o(b_level)
  );

  int checks = 0;
  int failures = 0;
  int resp_seen = 0;
  bit frame_en = 1'b0;

  // Reference model: plain game rules, scores kept for both instances.
  int m_state, m_lives, m_level, m_ticks;
  int m_score[2];
  int pts[2]  = '{1, 3};
  int smax[2] = '{255, 15};
  bit m_won, m_resp, m_kp, m_kprev, m_tick, m_fprev;
  bit alive[ROWS][COLS];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int n_alive();
    int n = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) n += alive[r][c];
    return n;
  endfunction

  function automatic logic [17:0] mask_vec();
    logic [17:0] v = '0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) v[r*COLS+c] = alive[r][c];
    return v;
  endfunction

  function automatic logic [4:0] onehot(input int s);
    logic [4:0] e = '0;
    e[4-s] = 1'b1;
    return e;
  endfunction

  task automatic fill();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) alive[r][c] = 1'b1;
  endtask

  task automatic model_step();
    int old, r, c;
    bit kp, tk, resp;
    if (rst) begin
      m_state = M_START; fill(); m_score[0] = 0; m_score[1] = 0; m_lives = 3; m_level = 1;
      m_won = 0; m_resp = 0; m_ticks = 0; m_kp = 0; m_kprev = 0; m_tick = 0; m_fprev = 0;
      return;
    end
    kp = m_kp; tk = m_tick; old = m_state; resp = 0; r = hr; c = hc;
    m_kp = (key == 8'h28) && !m_kprev;
    m_kprev = (key == 8'h28);
    m_tick = fclk && !m_fprev;
    m_fprev = fclk;
    case (m_state)
      M_START: if (kp) begin
        m_state = M_PLAY; fill(); m_score[0] = 0; m_score[1] = 0; m_lives = 3; m_level = 1;
      end
      M_PLAY: begin
        if (hv && r < ROWS && c < COLS) begin
          if (alive[r][c]) begin
            alive[r][c] = 0;
            for (int i = 0; i < 2; i++)
              m_score[i] = (m_score[i] + pts[i] > smax[i]) ? smax[i] : m_score[i] + pts[i];
          end
        end
        if (ph || el) begin
          m_state = M_DYING;
          if (m_lives > 0) m_lives--;
        end else if (n_alive() == 0) m_state = M_CLEAR;
      end
      M_DYING: if (tk) begin
        m_ticks++;
        if (m_ticks == 90) begin
          if (m_lives == 0) begin m_state = M_OVER; m_won = 0; end
          else begin resp = 1; m_state = (n_alive() == 0) ? M_CLEAR : M_PLAY; end
        end
      end
      M_CLEAR: if (tk) begin
        m_ticks++;
        if (m_ticks == 120) begin
          if (m_level == 4) begin m_state = M_OVER; m_won = 1; end
          else begin m_level++; fill(); m_state = M_PLAY; end
        end
      end
      default: if (kp) begin m_state = M_START; m_won = 0; end
    endcase
    if (m_state != old) m_ticks = 0;
    m_resp = resp;
  endtask

  task automatic compare_all();
    logic [24:0] rest_e;
    rest_e = {m_won, m_resp, 2'(m_lives), 3'(m_level), mask_vec()};
    check_eq("flags_a", {a_start, a_play, a_clear, a_dying, a_over}, onehot(m_state));
    check_eq("flags_b", {b_start, b_play, b_clear, b_dying, b_over}, onehot(m_state));
    check_eq("rest_a", {a_won, a_resp, a_lives, a_level, a_mask}, rest_e);
    check_eq("rest_b", {b_won, b_resp, b_lives, b_level, b_mask}, rest_e);
    check_eq("score_a", a_score, m_score[0]);
    check_eq("score_b", b_score, m_score[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (a_resp) resp_seen++;
    hv = 0; ph = 0; el = 0;
    fclk = frame_en && ($urandom_range(0, 2) == 0);
  endtask

  task automatic hit(input int r, input int c);
    hv = 1; hr = 2'(r); hc = 3'(c);
    cycle();
  endtask

  task automatic press_key();
    key = 8'h28; cycle();
    key = 8'h00; cycle(); cycle();
  endtask

  task automatic kill_until(input int keep);
    int guard = 0;
    while (n_alive() > keep && m_state == M_PLAY && guard < 2000) begin
      hit($urandom_range(0, 3), $urandom_range(0, 7));
      guard++;
    end
    check_eq("kill_budget", 32'(n_alive() <= keep), 32'd1);
  endtask

  task automatic wait_leave(input int s, input string tag);
    int n = 0;
    while (m_state == s && n < 3000) begin cycle(); n++; end
    check_eq(tag, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    int lr, lc;
    rst = 1; cycle(); cycle();
    check_eq("rst_flags", {a_start, a_play, a_clear, a_dying, a_over, a_won, a_resp}, 7'b1000000);
    check_eq("rst_mask", a_mask, 18'h3FFFF);
    rst = 0; cycle();

    key = 8'h28; repeat (5) cycle(); key = 8'h00; cycle();
    check_eq("t1_play", {a_start, a_play}, 2'b01);
    check_eq("t1_vals", {a_mask, a_score, a_lives, a_level}, {18'h3FFFF, 8'd0, 2'd3, 3'd1});

    hit(1, 2); hit(1, 2); hit(3, 0); hit(0, 6); hit(0, 7);
    check_eq("t2_score", a_score, 8'd1);
    check_eq("t2_mask", a_mask, 18'h3FEFF);

    frame_en = 1;
    for (int lvl = 1; lvl <= 4; lvl++) begin
      kill_until(0);
      check_eq("t3_clear", a_clear, 1'b1);
      wait_leave(M_CLEAR, "t3_clear_budget");
      check_eq("t3_score", a_score, 8'(18 * lvl));
      if (lvl < 4) check_eq("t3_lvl_up", {a_play, a_level, a_mask}, {1'b1, 3'(lvl + 1), 18'h3FFFF});
    end
    check_eq("t3_won", {a_over, a_won, b_score}, {1'b1, 1'b1, 4'd15});
    press_key();
    check_eq("t3_restart", a_start, 1'b1);

    press_key();
    resp_seen = 0;
    for (int i = 0; i < 3; i++) begin
      ph = 1; cycle();
      check_eq("t4_dying", {a_dying, a_lives}, {1'b1, 2'(2 - i)});
      wait_leave(M_DYING, "t4_dying_budget");
    end
    check_eq("t4_respawns", resp_seen, 2);
    check_eq("t4_lost", {a_over, a_won, a_lives}, {1'b1, 1'b0, 2'd0});
    press_key();
    check_eq("t4_start", a_start, 1'b1);

    press_key();
    kill_until(1);
    lr = 0; lc = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) if (alive[r][c]) begin lr = r; lc = c; end
    ph = 1; hit(lr, lc);
    check_eq("t5_last_kill", {a_dying, a_score, a_mask}, {1'b1, 8'd18, 18'h0});
    wait_leave(M_DYING, "t5_dying_budget");
    check_eq("t5_to_clear", {a_clear, a_play}, 2'b10);
    wait_leave(M_CLEAR, "t5_clear_budget");

    rst = 1; cycle(); rst = 0; cycle();
    press_key();
    kill_until(12);
    check_eq("t6_sat", {b_score, a_score}, {4'd15, 8'd6});
    ph = 1; cycle();
    check_eq("t6_dying", a_dying, 1'b1);
    rst = 1; cycle();
    check_eq("t6_rst", {a_start, a_dying, a_won, a_resp, a_mask, a_score, b_score, a_lives, a_level},
             {1'b1, 1'b0, 1'b0, 1'b0, 18'h3FFFF, 8'd0, 4'd0, 2'd3, 3'd1});
    rst = 0;

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0, 1: key = 8'h28;
        2: key = 8'h00;
        default: key = 8'($urandom_range(0, 255));
      endcase
      hv = $urandom_range(0, 1); hr = 2'($urandom_range(0, 3)); hc = 3'($urandom_range(0, 7));
      ph = ($urandom_range(0, 39) == 0);
      el = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 799) == 0);
      cycle();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
